// File: rtl/switch_cell_sched_pkg.sv
// Shared constants, state encoding and helpers for the switch cell scheduler.
// Beat-counter width is derived from the cell length so every user agrees on it.
package switch_sched_pkg;

  localparam int NPORT          = 4;
  localparam int CELL_BEATS_DEF = 4;
  localparam int BEAT_W_DEF     = $clog2(CELL_BEATS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_t;

  function automatic int beat_width(input int beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

  function automatic logic [NPORT-1:0] port_onehot(input logic [1:0] idx);
    logic [NPORT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/switch_cell_sched_if.sv
// Queue-side and port-FIFO-side signals of the cell scheduler.
// master = scheduler, slave = queues / output FIFOs.
interface switch_cell_sched_if;
  import switch_sched_pkg::*;

  logic [NPORT-1:0] q_req;
  logic [NPORT-1:0] q_last;
  logic [NPORT-1:0] o_cell_bp;
  logic [NPORT-1:0] q_rd;
  logic [1:0]       sched_port;
  logic [NPORT-1:0] o_cell_fifo_wr;
  logic             o_cell_first;
  logic             o_cell_last;

  modport master (
    input  q_req, q_last, o_cell_bp,
    output q_rd, sched_port, o_cell_fifo_wr, o_cell_first, o_cell_last
  );

  modport slave (
    output q_req, q_last, o_cell_bp,
    input  q_rd, sched_port, o_cell_fifo_wr, o_cell_first, o_cell_last
  );

endinterface

// File: rtl/switch_cell_sched_rr_arb4.sv
// Combinational 4-way round-robin picker: the first eligible port at or
// after rr_ptr wins, wrapping 3->0.
module rr_arb4 (
  input  logic [3:0] eligible,
  input  logic [1:0] rr_ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] rot;
  logic [1:0] offset;

  // rot[gi] is the port gi places after the pointer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    logic [1:0] idx;
    assign idx     = rr_ptr + 2'(gi);
    assign rot[gi] = eligible[idx];
  end

  always_comb begin
    offset = 2'd0;
    casez (rot)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
  end

  assign winner = rr_ptr + offset;
  assign any    = |eligible;

endmodule

// File: rtl/switch_cell_sched.sv
// Cell scheduler: grants one queue per frame round-robin and streams its
// cells beat by beat into the matching output-port FIFO.
module switch_cell_sched #(
  parameter int CELL_BEATS = switch_sched_pkg::CELL_BEATS_DEF,
  parameter int NPORT      = switch_sched_pkg::NPORT
) (
  input logic                 clk,
  input logic                 rst,
  switch_cell_sched_if.master bus
);
  import switch_sched_pkg::*;

  localparam int             BW        = beat_width(CELL_BEATS);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(CELL_BEATS - 1);

  sched_state_t     state_reg, state_next;
  logic [1:0]       rr_ptr_reg, rr_ptr_next;
  logic [1:0]       sched_port_reg, sched_port_next;
  logic [BW-1:0]    beat_reg, beat_next, beat_inc;
  logic             cell_is_last_reg, cell_is_last_next;
  logic [NPORT-1:0] q_rd_reg, q_rd_next;
  logic [NPORT-1:0] wr_reg, wr_next;
  logic             first_reg, first_next;
  logic             last_reg, last_next;

  logic [NPORT-1:0] eligible;
  logic [1:0]       winner;
  logic             any;
  logic             start_cell;
  logic [1:0]       start_port;
  logic             start_first;

  assign eligible = bus.q_req & ~bus.o_cell_bp;
  assign beat_inc = beat_reg + 1'b1;

  rr_arb4 u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_reg),
    .winner   (winner),
    .any      (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      rr_ptr_reg       <= 2'd0;
      sched_port_reg   <= 2'd0;
      beat_reg         <= '0;
      cell_is_last_reg <= 1'b0;
      q_rd_reg         <= '0;
      wr_reg           <= '0;
      first_reg        <= 1'b0;
      last_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      sched_port_reg   <= sched_port_next;
      beat_reg         <= beat_next;
      cell_is_last_reg <= cell_is_last_next;
      q_rd_reg         <= q_rd_next;
      wr_reg           <= wr_next;
      first_reg        <= first_next;
      last_reg         <= last_next;
    end
  end

  // Registered strobes describe the beat being presented in the coming cycle,
  // so eligibility and q_last are only ever looked at when a cell starts.
  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    sched_port_next   = sched_port_reg;
    beat_next         = beat_reg;
    cell_is_last_next = cell_is_last_reg;
    q_rd_next         = '0;
    wr_next           = '0;
    first_next        = 1'b0;
    last_next         = 1'b0;
    start_cell        = 1'b0;
    start_port        = sched_port_reg;
    start_first       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (any) begin
          start_cell  = 1'b1;
          start_port  = winner;
          start_first = 1'b1;
        end
      end
      ST_XFER: begin
        if (beat_reg != LAST_BEAT) begin
          beat_next = beat_inc;
          wr_next   = port_onehot(sched_port_reg);
          last_next = (beat_inc == LAST_BEAT) && cell_is_last_reg;
        end else if (cell_is_last_reg) begin
          rr_ptr_next = sched_port_reg + 2'd1;
          beat_next   = '0;
          state_next  = ST_IDLE;
        end else if (eligible[sched_port_reg]) begin
          start_cell = 1'b1;
        end else begin
          beat_next  = '0;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Mid-frame the grant stays locked; no other port may interleave.
        if (eligible[sched_port_reg]) begin
          start_cell = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (start_cell) begin
      state_next        = ST_XFER;
      sched_port_next   = start_port;
      beat_next         = '0;
      cell_is_last_next = bus.q_last[start_port];
      q_rd_next         = port_onehot(start_port);
      wr_next           = port_onehot(start_port);
      first_next        = start_first;
    end
  end

  assign bus.q_rd           = q_rd_reg;
  assign bus.sched_port     = sched_port_reg;
  assign bus.o_cell_fifo_wr = wr_reg;
  assign bus.o_cell_first   = first_reg;
  assign bus.o_cell_last    = last_reg;

endmodule
